// File: rtl/gshare_predictor_pkg.sv
// Shared types, opcode encodings and predictor FSM state encodings for the gshare direction predictor.
package gshare_predictor_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;
    typedef logic [31:0] data_t;

    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;

    localparam logic [OPC_MSB:OPC_LSB] OPCODE_JAL = 7'b1101111;
    localparam logic [OPC_MSB:OPC_LSB] OPCODE_BR  = 7'b1100011;

    typedef enum logic {
        BP_ST_INIT = 1'b0,
        BP_ST_RUN  = 1'b1
    } bp_state_e;

endpackage

// File: rtl/gshare_predictor_sat_counter_next.sv
// Saturating up/down counter next-value logic; purely combinational, clamps at 0 and all-ones.
module sat_counter_next #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cur_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] next_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_comb begin
        next_o = cur_i;
        if (inc_i) begin
            if (cur_i != CNT_MAX) next_o = cur_i + CNT_W'(1);
        end else begin
            if (cur_i != '0) next_o = cur_i - CNT_W'(1);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare IF-stage direction predictor: same-cycle prediction, GHR checkpointing, commit-time training.
// Optional commit statistics counters are built when PREDICTOR_STATS_EN is defined.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int IDX_W   = 8,
    parameter int CNT_W   = 2,
    parameter int GHR_LEN = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               query_valid,
    input  addr_t              query_pc,
    input  inst_t              query_inst,
    output logic               predicted_jump,
    output data_t              predicted_imm,
    output logic [GHR_LEN-1:0] predicted_ghr,
    output logic               ready,
    input  logic               ena_from_rob,
    input  logic               taken_from_rob,
    input  logic               mispredict_from_rob,
    input  addr_t              pc_from_rob,
    input  logic [GHR_LEN-1:0] ghr_from_rob,
    output data_t              stat_branches,
    output data_t              stat_mispredicts
);

    localparam int               DEPTH   = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

    bp_state_e          state_q;
    logic               ready_q;
    logic [IDX_W-1:0]   init_idx_q;
    logic [GHR_LEN-1:0] ghr_q, ghr_d;
    logic [CNT_W-1:0]   cnt_tbl_q [DEPTH];

    logic [OPC_MSB:OPC_LSB] opcode;
    logic                   is_jal, is_br;
    logic [IDX_W-1:0]       q_idx, u_idx;
    logic [CNT_W-1:0]       cnt_nxt;
    data_t                  imm_j, imm_b;

    // Only the word-index bits of the PCs feed the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{query_pc[31:IDX_W+2], query_pc[1:0],
                              pc_from_rob[31:IDX_W+2], pc_from_rob[1:0]};

    function automatic logic [GHR_LEN-1:0] ghr_push(input logic [GHR_LEN-1:0] h, input logic b);
        logic [GHR_LEN:0] t;
        t = {h, b};
        return t[GHR_LEN-1:0];
    endfunction

    assign opcode = query_inst[OPC_MSB:OPC_LSB];
    assign is_jal = (opcode == OPCODE_JAL);
    assign is_br  = (opcode == OPCODE_BR);

    assign q_idx = query_pc[IDX_W+1:2]    ^ IDX_W'(ghr_q);
    assign u_idx = pc_from_rob[IDX_W+1:2] ^ IDX_W'(ghr_from_rob);

    assign imm_j = {{12{query_inst[31]}}, query_inst[19:12], query_inst[20],
                    query_inst[30:21], 1'b0};
    assign imm_b = {{20{query_inst[31]}}, query_inst[7], query_inst[30:25],
                    query_inst[11:8], 1'b0};

    // Table read is the pre-update value, so a same-cycle commit to this index is not visible yet.
    assign predicted_jump = is_jal | (is_br & ready_q & cnt_tbl_q[q_idx][CNT_W-1]);
    assign predicted_imm  = is_jal ? imm_j : imm_b;
    assign predicted_ghr  = ghr_q;
    assign ready          = ready_q;

    sat_counter_next #(.CNT_W(CNT_W)) u_sat (
        .cur_i  (cnt_tbl_q[u_idx]),
        .inc_i  (taken_from_rob),
        .next_o (cnt_nxt)
    );

    // Recovery from the ROB beats the speculative shift: that query is on the wrong path.
    always_comb begin
        ghr_d = ghr_q;
        if (ena_from_rob && mispredict_from_rob)
            ghr_d = ghr_push(ghr_from_rob, taken_from_rob);
        else if (query_valid && is_br)
            ghr_d = ghr_push(ghr_q, predicted_jump);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BP_ST_INIT;
            ready_q    <= 1'b0;
            init_idx_q <= '0;
            ghr_q      <= '0;
        end else begin
            case (state_q)
                BP_ST_INIT: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == '1) begin
                        state_q <= BP_ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                BP_ST_RUN: ghr_q <= ghr_d;
                default: begin
                    state_q <= BP_ST_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!ready_q)
            cnt_tbl_q[init_idx_q] <= CNT_WNT;
        else if (ena_from_rob)
            cnt_tbl_q[u_idx] <= cnt_nxt;
    end

`ifdef PREDICTOR_STATS_EN
    data_t stat_br_q, stat_mp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (ready_q && ena_from_rob) begin
            if (stat_br_q != '1) stat_br_q <= stat_br_q + 32'd1;
            if (mispredict_from_rob && (stat_mp_q != '1)) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = 32'h0;
    assign stat_mispredicts = 32'h0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Randomized self-checking bench for gshare_predictor against a behavioural table/history model.
module tb_gshare_predictor;

    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_ALU  = 7'h13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        query_valid;
    logic [31:0] query_pc, query_inst;
    logic        predicted_jump;
    logic [31:0] predicted_imm;
    logic [5:0]  predicted_ghr;
    logic        ready;
    logic        ena_from_rob, taken_from_rob, mispredict_from_rob;
    logic [31:0] pc_from_rob;
    logic [5:0]  ghr_from_rob;
    logic [31:0] stat_branches, stat_mispredicts;

    int errors = 0;
    int checks = 0;

    // Reference model: integer counters, history as an integer, init progress as a count of writes.
    int          m_cnt [256];
    int          m_ghr;
    int          m_init_done;
    int unsigned m_br, m_mp;

    always #5 clk = ~clk;

    gshare_predictor dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .query_valid         (query_valid),
        .query_pc            (query_pc),
        .query_inst          (query_inst),
        .predicted_jump      (predicted_jump),
        .predicted_imm       (predicted_imm),
        .predicted_ghr       (predicted_ghr),
        .ready               (ready),
        .ena_from_rob        (ena_from_rob),
        .taken_from_rob      (taken_from_rob),
        .mispredict_from_rob (mispredict_from_rob),
        .pc_from_rob         (pc_from_rob),
        .ghr_from_rob        (ghr_from_rob),
        .stat_branches       (stat_branches),
        .stat_mispredicts    (stat_mispredicts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] inst);
        if ((inst & 32'h7F) == 32'h6F)
            return (((inst >> 21) & 32'h3FF) << 1) | (((inst >> 20) & 32'h1) << 11) |
                   (((inst >> 12) & 32'hFF) << 12) | (inst[31] ? 32'hFFF0_0000 : 32'h0);
        return (((inst >> 8) & 32'hF) << 1) | (((inst >> 25) & 32'h3F) << 5) |
               (((inst >> 7) & 32'h1) << 11) | (inst[31] ? 32'hFFFF_F000 : 32'h0);
    endfunction

    function automatic int ref_idx(input logic [31:0] pc, input int g);
        return int'((pc >> 2) & 32'hFF) ^ g;
    endfunction

    function automatic logic ref_jump();
        logic [31:0] op;
        op = query_inst & 32'h7F;
        if (op == 32'h6F) return 1'b1;
        if (op == 32'h63) return (m_init_done == 256) && (m_cnt[ref_idx(query_pc, m_ghr)] >= 2);
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_br();
`ifdef PREDICTOR_STATS_EN
        return m_br;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] exp_mp();
`ifdef PREDICTOR_STATS_EN
        return m_mp;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] mk_inst(input logic [6:0] op);
        logic [31:0] r;
        r = $urandom;
        r[6:0] = op;
        return r;
    endfunction

    task automatic model_reset();
        m_ghr = 0;
        m_init_done = 0;
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic check_outputs();
        check("ready", {31'b0, ready}, {31'b0, m_init_done == 256});
        check("ghr", {26'b0, predicted_ghr}, m_ghr);
        check("jump", {31'b0, predicted_jump}, {31'b0, ref_jump()});
        check("imm", predicted_imm, ref_imm(query_inst));
        check("stat_br", stat_branches, exp_br());
        check("stat_mp", stat_mispredicts, exp_mp());
    endtask

    // Check current outputs, advance the model by one clock edge, then step the DUT.
    task automatic tick();
        logic pj;
        int   u;
        #2;
        check_outputs();
        if (rst_n) begin
            if (m_init_done < 256) begin
                m_cnt[m_init_done] = 1;
                m_init_done++;
            end else begin
                pj = ref_jump();
                if (ena_from_rob) begin
                    u = ref_idx(pc_from_rob, int'(ghr_from_rob));
                    if (taken_from_rob) m_cnt[u] = (m_cnt[u] == 3) ? 3 : m_cnt[u] + 1;
                    else                m_cnt[u] = (m_cnt[u] == 0) ? 0 : m_cnt[u] - 1;
                    if (m_br != 32'hFFFF_FFFF) m_br++;
                    if (mispredict_from_rob && m_mp != 32'hFFFF_FFFF) m_mp++;
                end
                if (ena_from_rob && mispredict_from_rob)
                    m_ghr = ((int'(ghr_from_rob) << 1) | int'(taken_from_rob)) & 63;
                else if (query_valid && (query_inst[6:0] == OP_BR))
                    m_ghr = ((m_ghr << 1) | int'(pj)) & 63;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        query_valid = v;
        query_pc    = pc;
        query_inst  = inst;
    endtask

    task automatic set_rob(input logic e, input logic t, input logic m,
                           input logic [31:0] pc, input logic [5:0] g);
        ena_from_rob        = e;
        taken_from_rob      = t;
        mispredict_from_rob = m;
        pc_from_rob         = pc;
        ghr_from_rob        = g;
    endtask

    task automatic train(input logic [31:0] pc, input logic [5:0] g, input logic t, input logic m);
        set_rob(1'b1, t, m, pc, g);
        tick();
        set_rob(1'b0, 1'b0, 1'b0, 32'h0, 6'h0);
    endtask

    task automatic expect_jump(input string tag, input logic exp);
        #1;
        check(tag, {31'b0, predicted_jump}, {31'b0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_ready", {31'b0, ready}, 32'h0);
        check("rst_ghr", {26'b0, predicted_ghr}, 32'h0);
        check("rst_stat_br", stat_branches, 32'h0);
        check("rst_stat_mp", stat_mispredicts, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 1000) begin
            tick();
            n++;
        end
        check("init_len", n, 256);
    endtask

    task automatic random_cycle();
        logic [6:0] ops [4];
        ops = '{OP_JAL, OP_BR, OP_JALR, OP_ALU};
        set_q(1'($urandom_range(0, 1)),
              ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 63)) << 2),
              mk_inst(ops[$urandom_range(0, 3)]));
        set_rob($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                32'($urandom_range(0, 63)) << 2, 6'($urandom_range(0, 63)));
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        set_q(1'b0, 32'h0, 32'h0);
        set_rob(1'b0, 1'b0, 1'b0, 32'h0, 6'h0);
        #1;
        do_reset();
        wait_ready();

        // Freshly initialised counters are weakly not-taken.
        set_q(1'b0, 32'h100, 32'hFE00_0EE3);
        expect_jump("init_br", 1'b0);
        tick();

        set_q(1'b0, 32'h0, 32'h0080_006F);
        expect_jump("jal_jump", 1'b1);
        check("jal_imm8", predicted_imm, 32'h0000_0008);
        set_q(1'b0, 32'h0, 32'h0800_006F);
        #1 check("jal_imm80", predicted_imm, 32'h0000_0080);
        set_q(1'b0, 32'h0, 32'h0000_8067);
        expect_jump("jalr_jump", 1'b0);
        set_q(1'b0, 32'h0, 32'hFE00_0EE3);
        #1 check("br_imm", predicted_imm, 32'hFFFF_FFFC);
        tick();

        // Saturation at both ends of the counter at index 0x10.
        set_q(1'b0, 32'h40, 32'hFE00_0EE3);
        train(32'h40, 6'h0, 1'b1, 1'b0);
        train(32'h40, 6'h0, 1'b1, 1'b0);
        expect_jump("sat_t2", 1'b1);
        train(32'h40, 6'h0, 1'b1, 1'b0);
        train(32'h40, 6'h0, 1'b1, 1'b0);
        expect_jump("sat_t4", 1'b1);
        train(32'h40, 6'h0, 1'b0, 1'b0);
        expect_jump("sat_hi_n1", 1'b1);
        train(32'h40, 6'h0, 1'b0, 1'b0);
        expect_jump("sat_hi_n2", 1'b0);
        train(32'h40, 6'h0, 1'b0, 1'b0);
        train(32'h40, 6'h0, 1'b0, 1'b0);
        train(32'h40, 6'h0, 1'b1, 1'b0);
        expect_jump("sat_lo_t1", 1'b0);
        train(32'h40, 6'h0, 1'b1, 1'b0);
        expect_jump("sat_lo_t2", 1'b1);

        // Speculative history 1,0,1 then recovery overriding a concurrent query.
        train(32'h80, 6'h0, 1'b1, 1'b0);
        train(32'h80, 6'h0, 1'b1, 1'b0);
        set_q(1'b1, 32'h80, mk_inst(OP_BR));
        expect_jump("spec_q1", 1'b1);
        tick();
        set_q(1'b1, 32'h100, mk_inst(OP_BR));
        expect_jump("spec_q2", 1'b0);
        tick();
        set_q(1'b1, 32'h88, mk_inst(OP_BR));
        expect_jump("spec_q3", 1'b1);
        tick();
        set_q(1'b0, 32'h88, mk_inst(OP_BR));
        #1 check("spec_ghr", {26'b0, predicted_ghr}, 32'h05);
        set_rob(1'b1, 1'b0, 1'b1, 32'h200, 6'b000010);
        set_q(1'b1, 32'h88, mk_inst(OP_BR));
        tick();
        set_rob(1'b0, 1'b0, 1'b0, 32'h0, 6'h0);
        set_q(1'b0, 32'h88, mk_inst(OP_ALU));
        #1 check("recover_ghr", {26'b0, predicted_ghr}, 32'h04);

        // Same-index query and update in one cycle.
        set_rob(1'b1, 1'b1, 1'b0, 32'h240, 6'h0);
        set_q(1'b0, 32'h250, mk_inst(OP_BR));
        expect_jump("bypass_pre", 1'b0);
        tick();
        set_rob(1'b0, 1'b0, 1'b0, 32'h0, 6'h0);
        expect_jump("bypass_post", 1'b1);

        do_reset();
        wait_ready();

        for (int i = 0; i < 5; i++)
            train(32'h300 + 32'(i * 4), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), i == 1 || i == 3);
        #1;
`ifdef PREDICTOR_STATS_EN
        check("stats_br5", stat_branches, 32'd5);
        check("stats_mp2", stat_mispredicts, 32'd2);
`else
        check("stats_br_off", stat_branches, 32'd0);
        check("stats_mp_off", stat_mispredicts, 32'd0);
`endif
        do_reset();
        wait_ready();

        for (int i = 0; i < 3000; i++) random_cycle();

        // Reset landing in the middle of table initialisation.
        do_reset();
        for (int i = 0; i < 50; i++) random_cycle();
        set_q(1'b0, 32'h0, 32'h0);
        set_rob(1'b0, 1'b0, 1'b0, 32'h0, 6'h0);
        do_reset();
        wait_ready();
        for (int i = 0; i < 500; i++) random_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
